// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the unified-memory arbiter: FSM state codes,
// grant-source codes and the registered memory command record.
package mem_arbiter_pkg;

  typedef logic [1:0]  state_t;
  typedef logic [29:0] waddr_t;

  localparam state_t ST_IDLE   = 2'd0;
  localparam state_t ST_BUSY_I = 2'd1;
  localparam state_t ST_BUSY_D = 2'd2;
  localparam state_t ST_DONE   = 2'd3;

  localparam logic GNT_I = 1'b0;
  localparam logic GNT_D = 1'b1;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } mem_cmd_t;

  function automatic waddr_t word_addr(input logic [31:0] byte_addr);
    return byte_addr[31:2];
  endfunction

endpackage

// File: rtl/mem_arbiter_fetchbuf.sv
// One-entry instruction fetch buffer, present only when MEMARB_FETCH_BUF_EN
// is defined. Filled by every completed fetch, dropped by a matching store grant.
module memarb_fetchbuf
  import mem_arbiter_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        fill_i,
  input  waddr_t      fill_addr_i,
  input  logic [31:0] fill_data_i,
  input  logic        inv_i,
  input  waddr_t      inv_addr_i,
  input  waddr_t      lookup_addr_i,
  output logic        hit_o,
  output logic [31:0] data_o
);

  logic        valid_q, valid_d;
  waddr_t      addr_q, addr_d;
  logic [31:0] data_q, data_d;

  always_comb begin
    valid_d = valid_q;
    addr_d  = addr_q;
    data_d  = data_q;
    if (fill_i) begin
      valid_d = 1'b1;
      addr_d  = fill_addr_i;
      data_d  = fill_data_i;
    end else if (inv_i && (inv_addr_i == addr_q)) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  assign hit_o  = valid_q && (lookup_addr_i == addr_q);
  assign data_o = data_q;

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter sharing one single-ported memory between fetch and data ports.
// Optional fetch buffer is enabled by defining MEMARB_FETCH_BUF_EN.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_MAX = 4,
  parameter int unsigned CW         = 3
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        if_req_i,
  input  logic [31:0] if_addr_i,
  output logic [31:0] if_rdata_o,
  output logic        if_ready_o,
  input  logic        d_req_i,
  input  logic        d_we_i,
  input  logic [31:0] d_addr_i,
  input  logic [31:0] d_wdata_i,
  output logic [31:0] d_rdata_o,
  output logic        d_ready_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic [31:0] mem_rdata_i,
  input  logic        mem_ack_i
);

  localparam logic [CW-1:0] STARVE_LIM = CW'(STARVE_MAX);

  state_t        state_q, state_d;
  logic [CW-1:0] starve_q, starve_d;
  logic          mem_req_q, mem_req_d;
  mem_cmd_t      cmd_q, cmd_d;
  logic          if_ready_q, if_ready_d;
  logic          d_ready_q, d_ready_d;
  logic [31:0]   if_rdata_q, if_rdata_d;
  logic [31:0]   d_rdata_q, d_rdata_d;

  logic          fetch_wins;
  logic          gnt_src;
  logic          buf_hit;
  logic [31:0]   buf_data;

  // Fetch beats data only when it is alone or has been passed over STARVE_MAX times.
  assign fetch_wins = if_req_i && (!d_req_i || (starve_q == STARVE_LIM));
  assign gnt_src    = fetch_wins ? GNT_I : GNT_D;

`ifdef MEMARB_FETCH_BUF_EN
  logic buf_fill;
  logic buf_inv;

  assign buf_fill = (state_q == ST_BUSY_I) && mem_ack_i;
  assign buf_inv  = (state_q == ST_IDLE) && d_req_i && d_we_i && !fetch_wins;

  memarb_fetchbuf u_fetchbuf (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .fill_i        (buf_fill),
    .fill_addr_i   (word_addr(cmd_q.addr)),
    .fill_data_i   (mem_rdata_i),
    .inv_i         (buf_inv),
    .inv_addr_i    (word_addr(d_addr_i)),
    .lookup_addr_i (word_addr(if_addr_i)),
    .hit_o         (buf_hit),
    .data_o        (buf_data)
  );
`else
  assign buf_hit  = 1'b0;
  assign buf_data = '0;
`endif

  always_comb begin
    state_d    = state_q;
    starve_d   = starve_q;
    mem_req_d  = mem_req_q;
    cmd_d      = cmd_q;
    if_ready_d = 1'b0;
    d_ready_d  = 1'b0;
    if_rdata_d = if_rdata_q;
    d_rdata_d  = d_rdata_q;

    case (state_q)
      ST_IDLE: begin
        if (if_req_i || d_req_i) begin
          if (gnt_src == GNT_I) begin
            starve_d = '0;
            if (buf_hit) begin
              state_d    = ST_DONE;
              if_ready_d = 1'b1;
              if_rdata_d = buf_data;
            end else begin
              state_d   = ST_BUSY_I;
              mem_req_d = 1'b1;
              cmd_d     = '{we: 1'b0, addr: if_addr_i, wdata: 32'h0};
            end
          end else begin
            state_d   = ST_BUSY_D;
            mem_req_d = 1'b1;
            cmd_d     = '{we: d_we_i, addr: d_addr_i, wdata: d_wdata_i};
            if (if_req_i && (starve_q != STARVE_LIM)) begin
              starve_d = starve_q + 1'b1;
            end
          end
        end
      end

      ST_BUSY_I, ST_BUSY_D: begin
        if (mem_ack_i) begin
          state_d   = ST_DONE;
          mem_req_d = 1'b0;
          if (state_q == ST_BUSY_I) begin
            if_ready_d = 1'b1;
            if_rdata_d = mem_rdata_i;
          end else begin
            d_ready_d = 1'b1;
            d_rdata_d = mem_rdata_i;
          end
        end
      end

      // Requesters still hold req while ready is high, so nothing is sampled here.
      ST_DONE: state_d = ST_IDLE;

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ST_IDLE;
      starve_q   <= '0;
      mem_req_q  <= 1'b0;
      cmd_q      <= '0;
      if_ready_q <= 1'b0;
      d_ready_q  <= 1'b0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
    end else begin
      state_q    <= state_d;
      starve_q   <= starve_d;
      mem_req_q  <= mem_req_d;
      cmd_q      <= cmd_d;
      if_ready_q <= if_ready_d;
      d_ready_q  <= d_ready_d;
      if_rdata_q <= if_rdata_d;
      d_rdata_q  <= d_rdata_d;
    end
  end

  assign mem_req_o   = mem_req_q;
  assign mem_we_o    = cmd_q.we;
  assign mem_addr_o  = cmd_q.addr;
  assign mem_wdata_o = cmd_q.wdata;
  assign if_ready_o  = if_ready_q;
  assign if_rdata_o  = if_rdata_q;
  assign d_ready_o   = d_ready_q;
  assign d_rdata_o   = d_rdata_q;

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares one single-ported unified memory between the pipeline's instruction-fetch port and data-memory port. It sequences each access with a req/ack handshake toward memory and returns read data with a one-cycle ready pulse to the requester. The pipeline uses the inverse of each ready as a stall source: fetch stalls F/D, data stalls all stages. Data accesses have priority, and a starvation counter bounds how long fetch can wait.

## Interface
Parameters:
- STARVE_MAX, default 4: consecutive data grants with fetch pending before fetch is forced through.
- CW, default 3: width of the starvation counter; must satisfy 2^CW > STARVE_MAX.

Ports:
- clk  input  1  clock; all state changes on rising edge.
- reset  input  1  reset, asynchronous, active-low.
- if_req  input  1  fetch request; held stable with if_addr until if_ready.
- if_addr  input  32  fetch address (pcF).
- if_rdata  output  32  fetched instruction; valid while if_ready=1.
- if_ready  output  1  one-cycle completion pulse for fetch.
- d_req  input  1  data request; held stable with d_we, d_addr and d_wdata until d_ready.
- d_we  input  1  1 = store, 0 = load.
- d_addr  input  32  data address (aluoutM).
- d_wdata  input  32  store data (writedataM).
- d_rdata  output  32  load data; valid while d_ready=1.
- d_ready  output  1  one-cycle completion pulse for data.
- mem_req  output  1  memory request; held until mem_ack.
- mem_we  output  1  memory write enable.
- mem_addr  output  32  memory address.
- mem_wdata  output  32  memory write data.
- mem_rdata  input  32  memory read data; valid in the mem_ack cycle.
- mem_ack  input  1  memory completion; at most one cycle per request.

## Operation
- FSM states: IDLE, BUSY_I, BUSY_D, DONE.
- IDLE:
  - if_req only: grant fetch -> BUSY_I.
  - d_req only: grant data -> BUSY_D.
  - Both requested: data wins unless starve_cnt == STARVE_MAX, in which case fetch wins.
  - No request: stay in IDLE.
- BUSY_x:
  - mem_req=1; mem_addr, mem_we and mem_wdata are registered from the granted port at grant and held constant.
  - mem_we=0 for fetch.
  - On mem_ack: capture mem_rdata into x_rdata, assert x_ready, -> DONE.
- DONE:
  - Exactly one cycle; x_ready=1 for the served port only.
  - All requests are ignored in this cycle, because requesters still hold req while ready is high.
  - -> IDLE.
- starve_cnt:
  - Increments, saturating at STARVE_MAX, on each data grant made while if_req=1.
  - Clears on every fetch grant.
  - Unchanged otherwise.
- Read data: d_rdata for stores is don't-care but deterministic (captured mem_rdata). if_rdata and d_rdata hold their last captured value outside ready cycles.
- Ignored inputs:
  - mem_ack in IDLE or DONE is ignored.
  - A requester dropping req mid-BUSY is a protocol violation; the access still completes and ready still pulses.
- Reset (any time, including mid-BUSY):
  - State returns to IDLE.
  - All outputs reset to 0: mem_req, mem_we, mem_addr, mem_wdata, if_ready, d_ready, if_rdata, d_rdata.
  - starve_cnt=0 and the fetch buffer is invalidated.
  - An outstanding memory access is abandoned; a late mem_ack is ignored.

## Timing
- All outputs are registered; there are no combinational paths from inputs to outputs.
- Request sampled at edge k -> mem_req high from cycle k+1.
- mem_ack sampled at edge m -> x_ready and x_rdata in cycle m+1 -> IDLE at cycle m+2.
- With zero-wait memory (ack in the first mem_req cycle): req at cycle 0, mem_req at cycle 1, ready at cycle 2, next grant sampled at the end of cycle 3.
- Back-to-back throughput: one access per 3 cycles minimum.
- mem_req deasserts in the DONE cycle; there are never two outstanding requests.

## Configuration
- MEMARB_FETCH_BUF_EN defined: adds a one-entry fetch buffer holding buf_valid, buf_addr[31:2] and buf_data.
  - Fill: updated on every completed fetch.
  - Hit: in IDLE, when fetch would be granted and buf_valid and if_addr[31:2]==buf_addr, go straight to DONE with if_rdata=buf_data. There is no memory access, and the hit latency is 1 cycle to the ready pulse.
  - Invalidate: any data store grant with d_addr[31:2]==buf_addr clears buf_valid.
- Macro undefined: no buffer; every fetch goes to memory.

## Structure
- Shared package holds the FSM state enum (IDLE, BUSY_I, BUSY_D, DONE, 2-bit encoding) and a grant-source constant (GNT_I=0, GNT_D=1).
- One sub-module, memarb_fetchbuf, holds the optional fetch buffer. It is instantiated only under MEMARB_FETCH_BUF_EN.

## Test plan
- Single load: d_req=1, d_we=0, d_addr=0x40; memory acks 2 cycles after mem_req with 0xDEADBEEF -> mem_addr=0x40, mem_we=0, then d_ready=1 for one cycle with d_rdata=0xDEADBEEF, and if_ready stays 0.
- Simultaneous requests with STARVE_MAX=4, if_req held and d_req held continuously -> 4 data grants, then a fetch grant (5th), then starve_cnt=0 and data grants resume.
- Store: d_we=1, d_addr=0x80, d_wdata=0x12345678 -> mem_we=1 and mem_wdata=0x12345678, both stable until mem_ack; d_ready pulses once.
- Reset asserted mid-BUSY_D with mem_req=1 -> mem_req=0 immediately. A mem_ack one cycle after release produces no ready pulse, and the next if_req is served normally.
- Zero-wait memory with if_req held on the same address, without the macro -> if_ready at cycles 2, 5, 8 and so on, with no re-grant during DONE.
- With MEMARB_FETCH_BUF_EN:
  - Fetch 0x100 completes; a repeat fetch of 0x100 -> if_ready the next cycle with no mem_req.
  - A store to 0x100, then fetch 0x100 -> memory access occurs.
